// File: rtl/regfile_csr_pkg.sv
// Shared widths, CSR address map and write-bus payloads for the RV32I
// architectural state block.
package regfile_csr_pkg;

  localparam int unsigned REG_BUS_W      = 32;
  localparam int unsigned REG_ADDR_BUS_W = 5;
  localparam int unsigned CSR_ADDR_BUS_W = 12;
  localparam int unsigned NUM_GPR        = 32;
  localparam int unsigned CNT_W          = 64;
  localparam int unsigned CNT_HALF_W     = 32;

  typedef logic [REG_BUS_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;
  typedef logic [CSR_ADDR_BUS_W-1:0] csr_addr_bus_t;

  localparam csr_addr_bus_t csr_mstatus   = 12'h300;
  localparam csr_addr_bus_t csr_misa      = 12'h301;
  localparam csr_addr_bus_t csr_mie       = 12'h304;
  localparam csr_addr_bus_t csr_mtvec     = 12'h305;
  localparam csr_addr_bus_t csr_mscratch  = 12'h340;
  localparam csr_addr_bus_t csr_mepc      = 12'h341;
  localparam csr_addr_bus_t csr_mcause    = 12'h342;
  localparam csr_addr_bus_t csr_mtval     = 12'h343;
  localparam csr_addr_bus_t csr_mhartid   = 12'hF14;
  localparam csr_addr_bus_t csr_mcycle    = 12'hB00;
  localparam csr_addr_bus_t csr_mcycleh   = 12'hB80;
  localparam csr_addr_bus_t csr_minstret  = 12'hB02;
  localparam csr_addr_bus_t csr_minstreth = 12'hB82;
  localparam csr_addr_bus_t csr_cycle     = 12'hC00;
  localparam csr_addr_bus_t csr_cycleh    = 12'hC80;
  localparam csr_addr_bus_t csr_instret   = 12'hC02;
  localparam csr_addr_bus_t csr_instreth  = 12'hC82;

  typedef struct packed {
    logic          en;
    reg_addr_bus_t addr;
    reg_bus_t      data;
  } gpr_wr_t;

  typedef struct packed {
    logic          en;
    csr_addr_bus_t addr;
    reg_bus_t      data;
  } csr_wr_t;

  // CSRs that accept writes; only these may be bypassed to the read port.
  function automatic logic csr_writable(input csr_addr_bus_t addr);
    case (addr)
      csr_mstatus, csr_mie, csr_mtvec, csr_mscratch, csr_mepc, csr_mcause,
      csr_mtval, csr_mcycle, csr_mcycleh, csr_minstret, csr_minstreth:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with a half-word write port; a write to either half
// wins over the increment in that cycle.
module csr_counter64
  import regfile_csr_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  inc_i,
  input  logic                  wr_lo_i,
  input  logic                  wr_hi_i,
  input  logic [CNT_HALF_W-1:0] wdata_i,
  output logic [CNT_W-1:0]      count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[CNT_HALF_W-1:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[CNT_W-1:CNT_HALF_W] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/regfile_csr.sv
// RV32I GPR file and machine-mode CSR file with combinational read ports
// and same-cycle write-to-read bypass.
module regfile_csr
  import regfile_csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'h0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      read1_enable,
  input  logic [REG_ADDR_BUS_W-1:0] read1_address,
  output logic [REG_BUS_W-1:0]      read1_data,
  input  logic                      read2_enable,
  input  logic [REG_ADDR_BUS_W-1:0] read2_address,
  output logic [REG_BUS_W-1:0]      read2_data,
  input  logic                      csr_read1_enable,
  input  logic [CSR_ADDR_BUS_W-1:0] csr_read1_address,
  output logic [REG_BUS_W-1:0]      csr_read1_data,
  input  logic                      write_enable,
  input  logic [REG_ADDR_BUS_W-1:0] write_address,
  input  logic [REG_BUS_W-1:0]      write_data,
  input  logic                      csr_write_enable,
  input  logic [CSR_ADDR_BUS_W-1:0] csr_write_address,
  input  logic [REG_BUS_W-1:0]      csr_write_data,
  input  logic                      inst_retire_in
);

  gpr_wr_t  gpr_wr;
  csr_wr_t  csr_wr;
  reg_bus_t csr_wdata_c;
  reg_bus_t csr_stored_c;

  reg_bus_t gpr_q [1:NUM_GPR-1];
  reg_bus_t mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  reg_bus_t mstatus_d, mie_d, mtvec_d, mscratch_d, mepc_d, mcause_d, mtval_d;
  logic [CNT_W-1:0] mcycle, minstret;

  // Writes only take effect when the pipeline is ready.
  assign gpr_wr = '{en: write_enable & rdy_in, addr: write_address, data: write_data};
  assign csr_wr = '{en: csr_write_enable & rdy_in, addr: csr_write_address,
                    data: csr_write_data};

  assign csr_wdata_c = (csr_wr.addr == csr_mepc) ? {csr_wr.data[REG_BUS_W-1:2], 2'b00}
                                                 : csr_wr.data;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 1; i < NUM_GPR; i++) gpr_q[i] <= '0;
    end else if (gpr_wr.en && gpr_wr.addr != '0) begin
      gpr_q[gpr_wr.addr] <= gpr_wr.data;
    end
  end

  always_comb begin
    read1_data = '0;
    if (rst_in && read1_enable && read1_address != '0) begin
      if (gpr_wr.en && gpr_wr.addr == read1_address) read1_data = gpr_wr.data;
      else                                           read1_data = gpr_q[read1_address];
    end
  end

  always_comb begin
    read2_data = '0;
    if (rst_in && read2_enable && read2_address != '0) begin
      if (gpr_wr.en && gpr_wr.addr == read2_address) read2_data = gpr_wr.data;
      else                                           read2_data = gpr_q[read2_address];
    end
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (csr_wr.en) begin
      case (csr_wr.addr)
        csr_mstatus:  mstatus_d  = csr_wdata_c;
        csr_mie:      mie_d      = csr_wdata_c;
        csr_mtvec:    mtvec_d    = csr_wdata_c;
        csr_mscratch: mscratch_d = csr_wdata_c;
        csr_mepc:     mepc_d     = csr_wdata_c;
        csr_mcause:   mcause_d   = csr_wdata_c;
        csr_mtval:    mtval_d    = csr_wdata_c;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .en_i    (rdy_in),
    .inc_i   (1'b1),
    .wr_lo_i (csr_wr.en && csr_wr.addr == csr_mcycle),
    .wr_hi_i (csr_wr.en && csr_wr.addr == csr_mcycleh),
    .wdata_i (csr_wr.data),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_in),
    .rst_ni  (rst_in),
    .en_i    (rdy_in),
    .inc_i   (inst_retire_in),
    .wr_lo_i (csr_wr.en && csr_wr.addr == csr_minstret),
    .wr_hi_i (csr_wr.en && csr_wr.addr == csr_minstreth),
    .wdata_i (csr_wr.data),
    .count_o (minstret)
  );

  // Counter aliases read the registered value; no lookahead of this cycle's tick.
  always_comb begin
    case (csr_read1_address)
      csr_mstatus:                csr_stored_c = mstatus_q;
      csr_misa:                   csr_stored_c = MISA_VALUE;
      csr_mie:                    csr_stored_c = mie_q;
      csr_mtvec:                  csr_stored_c = mtvec_q;
      csr_mscratch:               csr_stored_c = mscratch_q;
      csr_mepc:                   csr_stored_c = mepc_q;
      csr_mcause:                 csr_stored_c = mcause_q;
      csr_mtval:                  csr_stored_c = mtval_q;
      csr_mhartid:                csr_stored_c = HART_ID;
      csr_mcycle,   csr_cycle:    csr_stored_c = mcycle[CNT_HALF_W-1:0];
      csr_mcycleh,  csr_cycleh:   csr_stored_c = mcycle[CNT_W-1:CNT_HALF_W];
      csr_minstret, csr_instret:  csr_stored_c = minstret[CNT_HALF_W-1:0];
      csr_minstreth, csr_instreth: csr_stored_c = minstret[CNT_W-1:CNT_HALF_W];
      default:                    csr_stored_c = '0;
    endcase
  end

  always_comb begin
    csr_read1_data = '0;
    if (rst_in && csr_read1_enable) begin
      if (csr_wr.en && csr_wr.addr == csr_read1_address && csr_writable(csr_read1_address))
        csr_read1_data = csr_wdata_c;
      else
        csr_read1_data = csr_stored_c;
    end
  end

endmodule

// File: tb/tb_regfile_csr.sv
// Self-checking bench for regfile_csr: directed vector table, hand-built
// counter/reset sequences, then randomized traffic against a reference model.
module tb_regfile_csr;

  localparam logic [31:0] T_MTVEC = 32'h0000_0100;
  localparam logic [31:0] T_MISA  = 32'h4000_0100;
  localparam logic [31:0] T_HART  = 32'h0000_0003;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        read1_enable, read2_enable, csr_read1_enable;
  logic [4:0]  read1_address, read2_address, write_address;
  logic [11:0] csr_read1_address, csr_write_address;
  logic [31:0] read1_data, read2_data, csr_read1_data, write_data, csr_write_data;
  logic        write_enable, csr_write_enable, inst_retire_in;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_csr #(.RESET_MTVEC(T_MTVEC), .MISA_VALUE(T_MISA), .HART_ID(T_HART)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .read1_enable(read1_enable), .read1_address(read1_address), .read1_data(read1_data),
    .read2_enable(read2_enable), .read2_address(read2_address), .read2_data(read2_data),
    .csr_read1_enable(csr_read1_enable), .csr_read1_address(csr_read1_address),
    .csr_read1_data(csr_read1_data),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .csr_write_enable(csr_write_enable), .csr_write_address(csr_write_address),
    .csr_write_data(csr_write_data), .inst_retire_in(inst_retire_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1;
    read1_enable = 1'b0; read1_address = '0;
    read2_enable = 1'b0; read2_address = '0;
    csr_read1_enable = 1'b0; csr_read1_address = '0;
    write_enable = 1'b0; write_address = '0; write_data = '0;
    csr_write_enable = 1'b0; csr_write_address = '0; csr_write_data = '0;
    inst_retire_in = 1'b0;
  endtask

  // Reset asserted at a falling edge, released at a later falling edge.
  task automatic do_reset();
    @(negedge clk_in);
    idle_inputs();
    rst_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  // Reads one CSR with the core frozen, so counters do not move during the read.
  task automatic csr_peek(input string name, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk_in);
    idle_inputs();
    rdy_in = 1'b0;
    csr_read1_enable = 1'b1; csr_read1_address = a;
    #1 chk(name, csr_read1_data, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_gpr [32];
  logic [31:0] m_csr [logic [11:0]];
  logic [63:0] m_mcyc, m_minst;

  function automatic bit is_plain(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};
  endfunction

  function automatic bit is_cnt_w(input logic [11:0] a);
    return a inside {12'hB00, 12'hB80, 12'hB02, 12'hB82};
  endfunction

  function automatic logic [31:0] m_stored(input logic [11:0] a);
    if (is_plain(a)) return m_csr.exists(a) ? m_csr[a] : 32'h0;
    case (a)
      12'h301: return T_MISA;
      12'hF14: return T_HART;
      12'hB00, 12'hC00: return m_mcyc[31:0];
      12'hB80, 12'hC80: return m_mcyc[63:32];
      12'hB02, 12'hC02: return m_minst[31:0];
      12'hB82, 12'hC82: return m_minst[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_csr.delete();
    m_csr[12'h305] = T_MTVEC;
    m_mcyc = '0;
    m_minst = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rdy; logic we; logic [4:0] wa; logic [31:0] wd;
    logic re1; logic [4:0] ra1; logic re2; logic [4:0] ra2;
    logic cwe; logic [11:0] cwa; logic [31:0] cwd; logic cre; logic [11:0] cra;
    logic [31:0] e1; logic [31:0] e2; logic [31:0] ec;
  } vec_t;

  vec_t vecs [11];

  localparam int unsigned N_ADDR = 18;
  logic [11:0] addr_list [N_ADDR];

  initial begin
    vecs[0]  = '{1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 0, 0, 12'h000, 32'h0,        1, 12'h301, 32'hDEADBEEF, 32'h0, T_MISA};
    vecs[1]  = '{1, 1, 0, 32'h00001234, 1, 5, 1, 0, 1, 12'h341, 32'h80000007, 1, 12'h341, 32'hDEADBEEF, 32'h0, 32'h80000004};
    vecs[2]  = '{1, 1, 7, 32'h00000055, 1, 7, 1, 7, 1, 12'h301, 32'h0,        1, 12'h301, 32'h55, 32'h55, T_MISA};
    vecs[3]  = '{1, 0, 0, 32'h0,        1, 7, 0, 7, 0, 12'h000, 32'h0,        1, 12'h341, 32'h55, 32'h0, 32'h80000004};
    vecs[4]  = '{1, 0, 0, 32'h0,        1, 0, 1, 5, 1, 12'h7C0, 32'h0000FFFF, 1, 12'h7C0, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1, 0, 0, 32'h0,        0, 5, 1, 5, 1, 12'h305, 32'h0000ABCD, 1, 12'h305, 32'h0, 32'hDEADBEEF, 32'hABCD};
    vecs[6]  = '{0, 1, 9, 32'h00000077, 1, 9, 1, 9, 1, 12'h340, 32'h00001111, 1, 12'h340, 32'h0, 32'h0, 32'h0};
    vecs[7]  = '{1, 0, 0, 32'h0,        1, 9, 1, 7, 0, 12'h000, 32'h0,        1, 12'h340, 32'h0, 32'h55, 32'h0};
    vecs[8]  = '{1, 0, 0, 32'h0,        1, 0, 1, 0, 0, 12'h000, 32'h0,        0, 12'hF14, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{1, 0, 0, 32'h0,        1, 5, 1, 0, 0, 12'h000, 32'h0,        1, 12'hF14, 32'hDEADBEEF, 32'h0, T_HART};
    vecs[10] = '{1, 0, 0, 32'h0,        1, 5, 1, 7, 0, 12'h000, 32'h0,        1, 12'h305, 32'hDEADBEEF, 32'h55, 32'hABCD};
    addr_list = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                  12'hC82, 12'h7C0};
  end

  initial begin
    idle_inputs();
    rst_in = 1'b0;

    // Outputs are forced low while reset is held, even with reads enabled.
    #2;
    read1_enable = 1'b1; read1_address = 5'd5;
    write_enable = 1'b1; write_address = 5'd5; write_data = 32'h1;
    csr_read1_enable = 1'b1; csr_read1_address = 12'h301;
    #1;
    chk("reset_read1", read1_data, 32'h0);
    chk("reset_csr", csr_read1_data, 32'h0);
    do_reset();
    csr_peek("reset_mtvec", 12'h305, T_MTVEC);
    csr_peek("reset_x5", 12'h000, 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk_in);
      rdy_in = vecs[i].rdy;
      write_enable = vecs[i].we; write_address = vecs[i].wa; write_data = vecs[i].wd;
      read1_enable = vecs[i].re1; read1_address = vecs[i].ra1;
      read2_enable = vecs[i].re2; read2_address = vecs[i].ra2;
      csr_write_enable = vecs[i].cwe; csr_write_address = vecs[i].cwa;
      csr_write_data = vecs[i].cwd;
      csr_read1_enable = vecs[i].cre; csr_read1_address = vecs[i].cra;
      inst_retire_in = 1'b0;
      #1;
      chk($sformatf("vec%0d_read1", i), read1_data, vecs[i].e1);
      chk($sformatf("vec%0d_read2", i), read2_data, vecs[i].e2);
      chk($sformatf("vec%0d_csr", i), csr_read1_data, vecs[i].ec);
    end

    // Asynchronous reset landing in the middle of a GPR write.
    @(negedge clk_in);
    idle_inputs();
    write_enable = 1'b1; write_address = 5'd3; write_data = 32'hAA;
    read1_enable = 1'b1; read1_address = 5'd5;
    read2_enable = 1'b1; read2_address = 5'd3;
    csr_read1_enable = 1'b1; csr_read1_address = 12'hB00;
    #1 chk("pre_areset_x5", read1_data, 32'hDEADBEEF);
    chk("pre_areset_bypass", read2_data, 32'hAA);
    #1 rst_in = 1'b0;
    #1;
    chk("areset_read1", read1_data, 32'h0);
    chk("areset_read2", read2_data, 32'h0);
    chk("areset_csr", csr_read1_data, 32'h0);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    write_enable = 1'b0;
    #1;
    chk("areset_x3_lost", read2_data, 32'h0);
    chk("areset_x5_clear", read1_data, 32'h0);
    chk("areset_mcycle", csr_read1_data, 32'h0);
    csr_read1_address = 12'h305;
    #1 chk("areset_mtvec", csr_read1_data, T_MTVEC);

    // Counters under rdy_in.
    do_reset();
    for (int i = 0; i < 9; i++) @(negedge clk_in);
    csr_peek("mcycle_10", 12'hB00, 32'd10);
    for (int i = 0; i < 4; i++) @(negedge clk_in);
    csr_peek("mcycle_frozen", 12'hB00, 32'd10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      idle_inputs();
      inst_retire_in = 1'b1;
    end
    csr_peek("minstret_3", 12'hB02, 32'd3);
    csr_peek("instret_alias_3", 12'hC02, 32'd3);
    csr_peek("cycle_alias_13", 12'hC00, 32'd13);
    csr_peek("minstreth_0", 12'hB82, 32'd0);

    // Carry into the high half, then a high-half write suppressing the tick.
    @(negedge clk_in);
    idle_inputs();
    csr_write_enable = 1'b1; csr_write_address = 12'hB00; csr_write_data = 32'hFFFF_FFFE;
    @(negedge clk_in);
    csr_write_address = 12'hB80; csr_write_data = 32'h0;
    @(negedge clk_in);
    csr_write_enable = 1'b0;
    @(negedge clk_in);
    csr_peek("carry_mcycleh", 12'hB80, 32'd1);
    csr_peek("carry_mcycle", 12'hB00, 32'd0);
    csr_peek("carry_cycleh", 12'hC80, 32'd1);
    @(negedge clk_in);
    idle_inputs();
    csr_write_enable = 1'b1; csr_write_address = 12'hB80; csr_write_data = 32'h5;
    csr_read1_enable = 1'b1; csr_read1_address = 12'hB80;
    #1 chk("mcycleh_bypass", csr_read1_data, 32'h5);
    csr_peek("mcycle_no_inc", 12'hB00, 32'd0);
    csr_peek("mcycleh_written", 12'hB80, 32'd5);
    csr_peek("cycle_alias_ro", 12'hC00, 32'd0);

    // Randomized traffic against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] e1, e2, ec;
      @(negedge clk_in);
      rdy_in = ($urandom_range(0, 4) != 0);
      write_enable = $urandom_range(0, 1) == 1;
      write_address = 5'($urandom_range(0, 7));
      write_data = $urandom;
      read1_enable = $urandom_range(0, 7) != 0;
      read1_address = 5'($urandom_range(0, 7));
      read2_enable = $urandom_range(0, 7) != 0;
      read2_address = 5'($urandom_range(0, 7));
      csr_write_enable = $urandom_range(0, 2) == 0;
      csr_write_address = addr_list[$urandom_range(0, N_ADDR - 1)];
      csr_write_data = $urandom;
      csr_read1_enable = $urandom_range(0, 7) != 0;
      csr_read1_address = ($urandom_range(0, 2) == 0) ? csr_write_address
                                                      : addr_list[$urandom_range(0, N_ADDR - 1)];
      inst_retire_in = $urandom_range(0, 1) == 1;

      e1 = 32'h0;
      if (read1_enable && read1_address != 0)
        e1 = (write_enable && rdy_in && write_address == read1_address) ? write_data
                                                                        : m_gpr[read1_address];
      e2 = 32'h0;
      if (read2_enable && read2_address != 0)
        e2 = (write_enable && rdy_in && write_address == read2_address) ? write_data
                                                                        : m_gpr[read2_address];
      ec = 32'h0;
      if (csr_read1_enable) begin
        if (csr_write_enable && rdy_in && csr_write_address == csr_read1_address &&
            (is_plain(csr_write_address) || is_cnt_w(csr_write_address)))
          ec = (csr_write_address == 12'h341) ? (csr_write_data & ~32'h3) : csr_write_data;
        else
          ec = m_stored(csr_read1_address);
      end
      #1;
      chk($sformatf("rnd%0d_read1", n), read1_data, e1);
      chk($sformatf("rnd%0d_read2", n), read2_data, e2);
      chk($sformatf("rnd%0d_csr", n), csr_read1_data, ec);

      if (rdy_in) begin
        if (write_enable && write_address != 0) m_gpr[write_address] = write_data;
        if (csr_write_enable && is_plain(csr_write_address))
          m_csr[csr_write_address] = (csr_write_address == 12'h341) ?
                                     (csr_write_data & ~32'h3) : csr_write_data;
        if (csr_write_enable && csr_write_address == 12'hB00)      m_mcyc[31:0]  = csr_write_data;
        else if (csr_write_enable && csr_write_address == 12'hB80) m_mcyc[63:32] = csr_write_data;
        else                                                        m_mcyc = m_mcyc + 64'd1;
        if (csr_write_enable && csr_write_address == 12'hB02)      m_minst[31:0]  = csr_write_data;
        else if (csr_write_enable && csr_write_address == 12'hB82) m_minst[63:32] = csr_write_data;
        else if (inst_retire_in)                                    m_minst = m_minst + 64'd1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
